// File: rtl/serial_link_obi_pkg.sv
// Shared OBI request/response types for the serial-link OBI port and the
// width helper used by the arbiter and its ID FIFO.
package serial_link_obi_pkg;

  localparam int unsigned ObiAddrW = 32;
  localparam int unsigned ObiDataW = 32;
  localparam int unsigned ObiBeW   = 4;

  typedef struct packed {
    logic                req;
    logic [ObiAddrW-1:0] addr;
    logic                we;
    logic [ObiBeW-1:0]   be;
    logic [ObiDataW-1:0] wdata;
  } sl_obi_req_t;

  typedef struct packed {
    logic                gnt;
    logic                rvalid;
    logic [ObiDataW-1:0] rdata;
  } sl_obi_resp_t;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_link_obi_id_fifo.sv
// Synchronous FIFO of requester indices, one entry per granted transaction
// still waiting for its rvalid.
module serial_link_obi_id_fifo
  import serial_link_obi_pkg::*;
#(
  parameter int unsigned Depth   = 4,
  parameter int unsigned IdWidth = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [IdWidth-1:0]     id_i,
  input  logic                   pop_i,
  output logic [IdWidth-1:0]     id_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = idx_width(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Depth-1:0][IdWidth-1:0] r_mem;
  logic [PtrW-1:0]               r_wr_ptr;
  logic [PtrW-1:0]               r_rd_ptr;
  logic [CntW-1:0]               r_count;
  logic                          w_push;
  logic                          w_pop;

  // Power-of-two depth lets the pointers wrap on their own; a single-entry
  // FIFO keeps its one-bit pointer pinned at zero.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (Depth == 1) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (r_count == CntW'(Depth));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign id_o    = r_mem[r_rd_ptr];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= id_i;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/serial_link_obi_arbiter.sv
// Round-robin arbiter sharing one serial-link OBI port among NumReq requesters;
// responses are steered back in grant order through an ID FIFO.
module serial_link_obi_arbiter
  import serial_link_obi_pkg::*;
#(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         obi_req_t      = sl_obi_req_t,
  parameter type         obi_resp_t     = sl_obi_resp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  obi_req_t  [NumReq-1:0] obi_req_i,
  output obi_resp_t [NumReq-1:0] obi_rsp_o,
  output obi_req_t               obi_req_o,
  input  obi_resp_t              obi_rsp_i,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int unsigned IdW   = idx_width(NumReq);
  localparam int unsigned Idx2W = idx_width(2 * NumReq);

  logic [NumReq-1:0]               w_req_vec;
  logic [2*NumReq-1:0]             w_req2;
  logic [IdW-1:0]                  r_rr_ptr;
  logic [IdW-1:0]                  r_lock_idx;
  logic                            r_locked;
  logic                            r_err;
  logic [IdW-1:0]                  w_winner;
  logic                            w_any;
  logic [IdW-1:0]                  w_sel;
  logic                            w_req_out;
  logic                            w_hs;
  logic [IdW-1:0]                  w_fifo_head;
  logic [IdW-1:0]                  w_rsp_idx;
  logic                            w_rsp_hit;
  logic                            w_bypass;
  logic                            w_fifo_push;
  logic                            w_fifo_pop;
  logic                            w_full;
  logic                            w_empty;
  logic [$clog2(MaxOutstanding):0] w_count;

  always_comb begin
    w_req_vec = '0;
    for (int unsigned k = 0; k < NumReq; k++) w_req_vec[k] = obi_req_i[k].req;
  end
  assign w_req2 = {w_req_vec, w_req_vec};

  // Scan downward so the last hit written is the closest one at or after rr_ptr.
  always_comb begin : rr_search
    logic [Idx2W-1:0] idx;
    idx      = '0;
    w_any    = 1'b0;
    w_winner = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      idx = Idx2W'(r_rr_ptr) + Idx2W'(i);
      if (w_req2[idx]) begin
        w_any    = 1'b1;
        w_winner = (idx >= Idx2W'(NumReq)) ? IdW'(idx - Idx2W'(NumReq)) : IdW'(idx);
      end
    end
  end

  assign w_sel = r_locked ? r_lock_idx : w_winner;

  // Full blocks the request from registered state only, so rvalid never reaches req.
  assign w_req_out = rst_ni && !w_full && obi_req_i[w_sel].req;
  assign w_hs      = w_req_out && obi_rsp_i.gnt;

  always_comb begin
    obi_req_o     = obi_req_i[w_sel];
    obi_req_o.req = w_req_out;
  end

  // An empty FIFO with a same-cycle handshake answers the transaction in flight.
  assign w_bypass    = w_empty && w_hs;
  assign w_rsp_idx   = w_empty ? w_sel : w_fifo_head;
  assign w_rsp_hit   = rst_ni && obi_rsp_i.rvalid && (!w_empty || w_hs);
  assign w_fifo_push = w_hs && !(w_bypass && obi_rsp_i.rvalid);
  assign w_fifo_pop  = obi_rsp_i.rvalid && !w_empty;

  always_comb begin
    obi_rsp_o = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      obi_rsp_o[k].gnt    = w_hs && (w_sel == IdW'(k));
      obi_rsp_o[k].rvalid = w_rsp_hit && (w_rsp_idx == IdW'(k));
      obi_rsp_o[k].rdata  = obi_rsp_o[k].rvalid ? obi_rsp_i.rdata : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rr_ptr   <= '0;
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err      <= obi_rsp_i.rvalid && w_empty && !w_hs;
      r_locked   <= w_req_out && !obi_rsp_i.gnt;
      r_lock_idx <= w_sel;
      if (w_hs) r_rr_ptr <= (w_sel == IdW'(NumReq - 1)) ? '0 : w_sel + IdW'(1);
    end
  end

  serial_link_obi_id_fifo #(
    .Depth   (MaxOutstanding),
    .IdWidth (IdW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_fifo_push),
    .id_i    (w_sel),
    .pop_i   (w_fifo_pop),
    .id_o    (w_fifo_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign busy_o = rst_ni && (w_count != '0);
  assign err_o  = r_err;

endmodule
